// File: rtl/fsm_round_sequencer.sv
// Master-side round sequencer for the FIRST/SECOND/THIRD odd/even/terminal FSM.
// Optional watchdog enabled by defining FSM_SEQ_TIMEOUT_EN.
module fsm_round_sequencer #(
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_rounds,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic               pause,
    output logic               restart,
    input  logic               fsm_odd,
    input  logic               fsm_even,
    input  logic               fsm_terminal,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   rounds_done,
    output logic               err,
    output logic               timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   target;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [1:0]         phase;
    logic               idle_first;

    logic               accept;
    logic               in_run;
    logic               term_exp;
    logic               viol;
    logic               count;
    logic               last;
    logic               wd_hit;
    logic [CNT_W-1:0]   rounds_inc;

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign restart    = (state != S_RUN);
    assign pause      = restart | (dwell_cnt != '0);
    assign accept     = cmd_valid & cmd_ready;
    assign in_run     = (state == S_RUN);
    assign term_exp   = in_run & (phase == 2'd2) & ~pause;
    assign rounds_inc = rounds_done + 1'b1;

    // THIRD may still show terminal on the first IDLE cycle after an abort.
    assign viol = (fsm_odd == fsm_even)
                | (in_run & (fsm_even != (phase == 2'd1)))
                | (in_run & (fsm_terminal != term_exp))
                | ((state == S_DONE) & fsm_terminal)
                | ((state == S_IDLE) & ~idle_first & fsm_terminal);

    assign count = in_run & fsm_terminal & (rounds_done != target);
    assign last  = count & (rounds_inc == target);

`ifdef FSM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;

    assign wd_hit = in_run & ~fsm_terminal & (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept) begin
                wd      <= '0;
                timeout <= 1'b0;
            end else if (in_run) begin
                wd <= fsm_terminal ? '0 : wd + 1'b1;
                if (wd_hit) timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            target      <= '0;
            dwell       <= '0;
            dwell_cnt   <= '0;
            phase       <= 2'd0;
            idle_first  <= 1'b0;
            done        <= 1'b0;
            rounds_done <= '0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= err | viol | wd_hit;
            unique case (state)
                S_IDLE: begin
                    idle_first <= 1'b0;
                    if (accept) begin
                        target      <= cmd_rounds;
                        dwell       <= cmd_dwell;
                        dwell_cnt   <= cmd_dwell;
                        phase       <= 2'd0;
                        rounds_done <= '0;
                        err         <= 1'b0;
                        if (cmd_rounds == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        dwell_cnt <= dwell;
                        phase     <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    end
                    if (count) rounds_done <= rounds_inc;
                    // Abort and watchdog win over a final terminal.
                    if (abort | wd_hit) begin
                        state      <= S_IDLE;
                        idle_first <= 1'b1;
                    end else if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    idle_first <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
